// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 3-sample majority per bit, 8 data bits LSB first,
// optional parity, stop-bit check and a one-clock rdsig strobe per received frame.
module uart_rx #(
    parameter logic PARITY_EN   = 1'b0,
    parameter logic PARITY_MODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       rdsig,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WAIT_HIGH
    } state_t;

    // Count value at which the stop bit is decided, and its slot index.
    localparam logic [7:0] LAST_CNT = PARITY_EN ? 8'd169 : 8'd153;
    localparam logic [3:0] STOP_K   = PARITY_EN ? 4'd10 : 4'd9;

    logic       sync1_q, sync2_q;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] smp_q, smp_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       stop_q, stop_d;
    logic [7:0] dataout_q, dataout_d;
    logic       rdsig_q, rdsig_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       busy_q, busy_d;

    logic       rx_s;
    logic       maj;
    logic [3:0] slot;

    assign rx_s = sync2_q;
    assign slot = cnt_q[7:4];
    assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            smp_q     <= 2'b11;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            stop_q    <= 1'b1;
            dataout_q <= 8'd0;
            rdsig_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            smp_q     <= smp_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            dataout_q <= dataout_d;
            rdsig_q   <= rdsig_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        smp_d     = smp_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop_d    = stop_q;
        dataout_d = dataout_q;
        rdsig_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = RECV;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b1;
                end
            end

            RECV: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q[3:0] == 4'd7) smp_d[0] = rx_s;
                if (cnt_q[3:0] == 4'd8) smp_d[1] = rx_s;

                if (cnt_q == LAST_CNT + 8'd1) begin
                    // Frame complete: publish byte and flags together.
                    rdsig_d   = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = 8'd0;
                    dataout_d = shift_q;
                    ferr_d    = ~stop_q;
                    perr_d    = PARITY_EN & (par_q ^ (^shift_q) ^ PARITY_MODE);
                    state_d   = stop_q ? IDLE : WAIT_HIGH;
                end else if (cnt_q[3:0] == 4'd9) begin
                    if (slot == 4'd0) begin
                        if (maj) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            cnt_d   = 8'd0;
                        end
                    end else if (slot <= 4'd8) begin
                        shift_d = {maj, shift_q[7:1]};
                    end else if (slot == STOP_K) begin
                        stop_d = maj;
                    end else begin
                        par_d = maj;
                    end
                end
            end

            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign dataout    = dataout_q;
    assign rdsig      = rdsig_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames into an 8N1 and an even-parity instance,
// expected bytes queued at stimulus time and checked by per-instance monitors.
module tb_uart_rx;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx_n, rx_p;
    logic [7:0] dout_n, dout_p;
    logic       rdsig_n, rdsig_p;
    logic       perr_n, perr_p;
    logic       ferr_n, ferr_p;
    logic       busy_n, busy_p;

    exp_t q_n[$];
    exp_t q_p[$];
    int   n_cmp;
    int   n_err;
    logic prev_busy_n, prev_busy_p;

    uart_rx #(.PARITY_EN(1'b0), .PARITY_MODE(1'b0)) u_n (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_n),
        .dataout   (dout_n),
        .rdsig     (rdsig_n),
        .parity_err(perr_n),
        .frame_err (ferr_n),
        .busy      (busy_n)
    );

    uart_rx #(.PARITY_EN(1'b1), .PARITY_MODE(1'b0)) u_p (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_p),
        .dataout   (dout_p),
        .rdsig     (rdsig_p),
        .parity_err(perr_p),
        .frame_err (ferr_p),
        .busy      (busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_p = v;
        else rx_n = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // pbit < 0 means no parity slot; one clock of slot gl_slot at offset gl_clk is inverted.
    task automatic send(input bit sel, input logic [7:0] b, input int pbit,
                        input int stop_clks, input int gl_slot, input int gl_clk);
        int   nslots;
        int   len;
        logic v;
        nslots = (pbit >= 0) ? 11 : 10;
        for (int s = 0; s < nslots; s++) begin
            if (s == 0) v = 1'b0;
            else if (s <= 8) v = b[s-1];
            else if (pbit >= 0 && s == 9) v = (pbit != 0);
            else v = 1'b1;
            len = (s == nslots - 1) ? stop_clks : 16;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                set_rx(sel, v ^ (s == gl_slot && c == gl_clk));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rdsig_n) begin
            if (q_n.size() == 0) begin
                chk("n_unexpected_rdsig", 1, 0);
            end else begin
                exp_t e;
                e = q_n.pop_front();
                chk("n_dataout", int'(dout_n), int'(e.d));
                chk("n_parity_err", int'(perr_n), int'(e.pe));
                chk("n_frame_err", int'(ferr_n), int'(e.fe));
                chk("n_busy_fall", int'({prev_busy_n, busy_n}), 2);
            end
        end
        prev_busy_n = busy_n;
    end

    always @(negedge clk) begin
        if (rst_n && rdsig_p) begin
            if (q_p.size() == 0) begin
                chk("p_unexpected_rdsig", 1, 0);
            end else begin
                exp_t e;
                e = q_p.pop_front();
                chk("p_dataout", int'(dout_p), int'(e.d));
                chk("p_parity_err", int'(perr_p), int'(e.pe));
                chk("p_frame_err", int'(ferr_p), int'(e.fe));
                chk("p_busy_fall", int'({prev_busy_p, busy_p}), 2);
            end
        end
        prev_busy_p = busy_p;
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        rx_n  = 1'b1;
        rx_p  = 1'b1;
        idle(4);
        chk("rst_dataout", int'(dout_n), 0);
        chk("rst_rdsig", int'(rdsig_n), 0);
        chk("rst_errs", int'({perr_n, ferr_n}), 0);
        chk("rst_busy", int'(busy_n), 0);
        rst_n = 1'b1;
        idle(5);

        // Plain 8N1 frame with the short uart_tx stop.
        q_n.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b0});
        send(1'b0, 8'h55, -1, 13, -1, 0);
        idle(20);

        // False start: five low clocks.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx_n = 1'b0;
        end
        @(negedge clk);
        chk("fs_busy_high", int'(busy_n), 1);
        rx_n = 1'b1;
        idle(12);
        chk("fs_busy_low", int'(busy_n), 0);
        chk("fs_dataout_held", int'(dout_n), 8'h55);
        idle(20);

        // Back-to-back frames.
        q_n.push_back('{d: 8'hA3, pe: 1'b0, fe: 1'b0});
        q_n.push_back('{d: 8'h0F, pe: 1'b0, fe: 1'b0});
        send(1'b0, 8'hA3, -1, 13, -1, 0);
        send(1'b0, 8'h0F, -1, 13, -1, 0);
        idle(20);

        // Glitch on the middle sample of data bit 3.
        q_n.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b0});
        send(1'b0, 8'h00, -1, 16, 4, 9);
        idle(20);

        // Even parity: 0x01 needs parity bit 1.
        q_p.push_back('{d: 8'h01, pe: 1'b1, fe: 1'b0});
        send(1'b1, 8'h01, 0, 16, -1, 0);
        idle(20);
        q_p.push_back('{d: 8'h01, pe: 1'b0, fe: 1'b0});
        send(1'b1, 8'h01, 1, 16, -1, 0);
        idle(20);

        // Break, then recovery frame.
        q_n.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
        @(negedge clk);
        rx_n = 1'b0;
        idle(400);
        rx_n = 1'b1;
        idle(20);
        q_n.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
        send(1'b0, 8'h3C, -1, 16, -1, 0);
        idle(20);

        // Reset in the middle of 0xFF, then a clean frame.
        for (int c = 0; c < 73; c++) begin
            @(negedge clk);
            rx_n = (c < 16) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        idle(3);
        chk("mid_rst_dataout", int'(dout_n), 0);
        chk("mid_rst_flags", int'({rdsig_n, perr_n, ferr_n, busy_n}), 0);
        rst_n = 1'b1;
        idle(120);
        q_n.push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b0});
        send(1'b0, 8'hC3, -1, 16, -1, 0);
        idle(30);

        chk("n_all_received", q_n.size(), 0);
        chk("p_all_received", q_p.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
